// File: rtl/fifo_pkg.sv
// Shared definitions for the sync FIFO and its write-side arbiter.
package fifo_pkg;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping mod NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       vld
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan farthest-first so the nearest candidate after ptr overwrites the rest.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port; zero-latency pass-through.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write_en,
  output logic [DATA_W-1:0]           fifo_write_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        grant_vld,
  output logic                        locked
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, rr_ptr_q, pick_idx, select;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             pick_vld, accept, release_grant;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = release_grant ? ARB_IDLE : ARB_OWNED;
  end

  // An owner keeps the port even while its own valid is low.
  always_comb begin
    select    = (state_q == ARB_OWNED) ? owner_q : pick_idx;
    grant_vld = (state_q == ARB_OWNED) || pick_vld;
    accept    = grant_vld && req_valid[select] && !fifo_full;
    release_grant = accept &&
                    (req_last[select] || ((MAX_BURST != 0) && (beat_cnt_q == BURST_LAST)));
    grant_id      = select;
    fifo_write_en = accept;
    locked        = (state_q == ARB_OWNED);
    req_ready       = '0;
    fifo_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (select == IDX_W'(i)) begin
        req_ready[i]    = accept;
        fifo_write_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      if (release_grant) begin
        rr_ptr_q   <= select;
        beat_cnt_q <= '0;
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        if (state_q == ARB_IDLE) owner_q <= select;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_write_en, grant_vld, locked;
  logic [DW-1:0]   fifo_write_data;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .grant_id(grant_id), .grant_vld(grant_vld), .locked(locked)
  );

  int n_chk = 0, n_fail = 0;
  bit m_owned;
  int m_owner, m_cnt, m_rr;
  int e_sel;
  bit e_gv, e_acc, e_rel;
  int rem[N];
  int wr_ids[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: owner wins outright; otherwise nearest valid after the last releaser.
  task automatic model_eval();
    e_gv  = 1'b0;
    e_sel = 0;
    if (m_owned) begin
      e_gv  = 1'b1;
      e_sel = m_owner;
    end else begin
      for (int k = 1; k <= N; k++)
        if (!e_gv && req_valid[(m_rr + k) % N]) begin
          e_gv  = 1'b1;
          e_sel = (m_rr + k) % N;
        end
    end
    e_acc = e_gv && req_valid[e_sel] && !fifo_full;
    e_rel = e_acc && (req_last[e_sel] || (MB != 0 && m_cnt == MB - 1));
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_eval();
    check("ready", req_ready, e_acc ? (1 << e_sel) : 0);
    check("wr_en", fifo_write_en, e_acc);
    check("gvld", grant_vld, e_gv);
    check("locked", locked, m_owned);
    if (e_gv)  check("gid", grant_id, e_sel);
    if (e_acc) check("wdata", fifo_write_data, req_data[e_sel*DW +: DW]);
    if (fifo_write_en) wr_ids.push_back(int'(grant_id));
  endtask

  task automatic at_pos();
    @(posedge clk);
    if (reset) begin
      m_owned = 1'b0; m_owner = 0; m_cnt = 0; m_rr = N - 1;
    end else if (e_acc) begin
      if (e_rel) begin
        m_owned = 1'b0; m_cnt = 0; m_rr = e_sel;
      end else begin
        if (!m_owned) m_owner = e_sel;
        m_owned = 1'b1;
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic cyc();
    at_neg();
    at_pos();
  endtask

  task automatic drive(int i, bit v, bit l, logic [DW-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    e_acc = 1'b0; e_rel = 1'b0; e_sel = 0;
    at_pos();
    at_pos();
    reset = 1'b0;

    // reset state, idle
    at_neg();
    check("rst_gvld", grant_vld, 0);
    check("rst_wen", fifo_write_en, 0);
    check("rst_rdy", req_ready, 0);
    check("rst_lock", locked, 0);
    at_pos();

    // 1: single-beat packets from 1 and 3 alternate
    do_reset();
    drive(1, 1, 1, 8'h11);
    drive(3, 1, 1, 8'h33);
    for (int j = 0; j < 3; j++) begin
      at_neg();
      check("t1_gid", grant_id, (j == 1) ? 3 : 1);
      at_pos();
    end

    // 2: 4-beat packet from 0 blocks 2; locked on beats 2-4
    do_reset();
    drive(2, 1, 1, 8'h22);
    for (int b = 0; b < 4; b++) begin
      drive(0, 1, b == 3, DW'(8'hA0 + b));
      at_neg();
      check("t2_gid", grant_id, 0);
      check("t2_lock", locked, b != 0);
      at_pos();
    end
    drive(0, 0, 0, 8'h00);
    at_neg();
    check("t2_next", grant_id, 2);
    at_pos();

    // 3: full for 3 cycles mid-packet
    do_reset();
    drive(1, 1, 1, 8'h55);
    drive(0, 1, 0, 8'hB0);
    cyc();
    fifo_full = 1'b1;
    drive(0, 1, 0, 8'hB1);
    for (int j = 0; j < 3; j++) begin
      at_neg();
      check("t3_wen", fifo_write_en, 0);
      check("t3_rdy", req_ready, 0);
      check("t3_gid", grant_id, 0);
      at_pos();
    end
    fifo_full = 1'b0;
    for (int b = 1; b < 4; b++) begin
      drive(0, 1, b == 3, DW'(8'hB0 + b));
      at_neg();
      check("t3_resume", fifo_write_en, 1);
      check("t3_rgid", grant_id, 0);
      at_pos();
    end
    drive(0, 0, 0, 8'h00);
    cyc();

    // 4: 10-beat packet from 1 is split by MAX_BURST around req 3
    do_reset();
    wr_ids.delete();
    begin
      int r1 = 10;
      bit r3 = 1'b1;
      drive(3, 1, 1, 8'h33);
      for (int c = 0; c < 30 && (r1 > 0 || r3); c++) begin
        if (r1 > 0) drive(1, 1, r1 == 1, DW'(8'hC0 + r1));
        else        drive(1, 0, 0, 8'h00);
        cyc();
        if (e_acc && e_sel == 1) r1--;
        if (e_acc && e_sel == 3) begin r3 = 1'b0; drive(3, 0, 0, 8'h00); end
      end
      drive(1, 0, 0, 8'h00);
    end
    check("t4_n", wr_ids.size(), 11);
    for (int k = 0; k < 11 && k < wr_ids.size(); k++)
      check("t4_seq", wr_ids[k], (k == 8) ? 3 : 1);

    // 5: owner stalls; others wait
    do_reset();
    drive(0, 1, 0, 8'hA0);
    cyc();
    drive(0, 0, 0, 8'h00);
    drive(1, 1, 1, 8'h11);
    drive(2, 1, 1, 8'h22);
    for (int j = 0; j < 2; j++) begin
      at_neg();
      check("t5_gid", grant_id, 0);
      check("t5_gvld", grant_vld, 1);
      check("t5_rdy", req_ready, 0);
      at_pos();
    end
    drive(0, 1, 1, 8'hA1);
    at_neg();
    check("t5_rdy0", req_ready, 1);
    at_pos();

    // 6: reset while owned returns to req-0 priority
    do_reset();
    drive(2, 1, 0, 8'h20);
    cyc();
    check("t6_own", locked, 1);
    reset = 1'b1;
    drive(0, 1, 0, 8'h01);
    cyc();
    reset = 1'b0;
    at_neg();
    check("t6_lock", locked, 0);
    check("t6_gid", grant_id, 0);
    check("t6_gvld", grant_vld, 1);
    check("t6_cnt", dut.beat_cnt_q, 0);
    at_pos();

    // randomized traffic, packets up to 12 beats, random backpressure
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 12);
          if (rem[i] > 0 && $urandom_range(0, 9) < 7) drive(i, 1, rem[i] == 1, DW'($urandom));
        end
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      cyc();
      if (e_acc) begin
        rem[e_sel]--;
        req_valid[e_sel] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
